// File: rtl/vis_pkg.sv
// Shared definitions for the visibility stream buffer: read FSM states,
// the default component width and {imag, real} word packing helpers.
package vis_pkg;

  localparam int VIS_WIDTH = 7;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

  function automatic logic [2*VIS_WIDTH-1:0] pack_vis(
    input logic signed [VIS_WIDTH-1:0] re,
    input logic signed [VIS_WIDTH-1:0] im
  );
    return {im, re};
  endfunction

  function automatic logic signed [VIS_WIDTH-1:0] unpack_re(
    input logic [2*VIS_WIDTH-1:0] word
  );
    return word[VIS_WIDTH-1:0];
  endfunction

  function automatic logic signed [VIS_WIDTH-1:0] unpack_im(
    input logic [2*VIS_WIDTH-1:0] word
  );
    return word[2*VIS_WIDTH-1:VIS_WIDTH];
  endfunction

endpackage

// File: rtl/vis_skid_buffer.sv
// Two-entry output register slice carrying data and last. Outputs come straight
// from flops, so m_valid never depends combinationally on m_ready.
module vis_skid_buffer #(
  parameter int DW = 14
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  logic          skid_vld;
  logic [DW-1:0] skid_data;
  logic          skid_last;
  logic          pop;

  assign pop     = m_valid && m_ready;
  assign s_ready = !skid_vld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else if (!m_valid || pop) begin
      // Head is free this edge: refill from the skid entry first to keep order.
      if (skid_vld) begin
        m_valid  <= 1'b1;
        m_data   <= skid_data;
        m_last   <= skid_last;
        skid_vld <= s_valid;
        if (s_valid) begin
          skid_data <= s_data;
          skid_last <= s_last;
        end
      end else begin
        m_valid <= s_valid;
        if (s_valid) begin
          m_data <= s_data;
          m_last <= s_last;
        end
      end
    end else if (s_valid) begin
      skid_vld  <= 1'b1;
      skid_data <= s_data;
      skid_last <= s_last;
    end
  end

endmodule

// File: rtl/vis_stream_buffer.sv
// Ping-pong capture of accumulator bursts and in-order replay on an AXI4-Stream
// master; a burst arriving with no free bank is dropped whole and flagged.
module vis_stream_buffer
  import vis_pkg::*;
#(
  parameter int WIDTH = VIS_WIDTH,
  parameter int PSUMS = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    frame_i,
  input  logic                    valid_i,
  input  logic                    first_i,
  input  logic                    last_i,
  input  logic signed [WIDTH-1:0] rdata_i,
  input  logic signed [WIDTH-1:0] idata_i,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [2*WIDTH-1:0]      m_tdata,
  output logic                    drop_o
);

  localparam int ABITS = $clog2(PSUMS + 1);
  localparam int DEPTH = 2 * PSUMS;
  localparam int MBITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ABITS-1:0] FULL_LEN = ABITS'(PSUMS);
  localparam logic [ABITS-1:0] ONE      = ABITS'(1);

  function automatic logic [MBITS-1:0] mem_addr(
    input logic             bank,
    input logic [ABITS-1:0] a
  );
    return bank ? MBITS'(PSUMS + int'(a)) : MBITS'(a);
  endfunction

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [1:0]       full;
  logic [ABITS-1:0] len_q [2];
  logic             wr_bank;
  logic             wr_open;
  logic             wr_drop;
  logic [ABITS-1:0] wr_addr;

  logic             word_in;
  logic             start;
  logic             start_ok;
  logic             wr_en;
  logic             commit;
  logic [ABITS-1:0] wr_slot;
  logic [ABITS-1:0] wr_len;
  logic [1:0]       wr_sel;

  always_comb begin
    word_in  = frame_i && valid_i;
    start    = word_in && first_i;
    start_ok = start && !full[wr_bank];
    wr_slot  = start ? '0 : wr_addr;
    // Words past the bank depth are discarded rather than wrapped.
    wr_en    = (start_ok || (word_in && !first_i && wr_open)) && (wr_slot < FULL_LEN);
    commit   = word_in && last_i && (start_ok || (!first_i && wr_open));
    wr_len   = wr_en ? wr_slot + ONE : wr_slot;
    wr_sel   = {wr_bank, !wr_bank};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      wr_open  <= 1'b0;
      wr_drop  <= 1'b0;
      wr_addr  <= '0;
      drop_o   <= 1'b0;
      len_q[0] <= '0;
      len_q[1] <= '0;
    end else begin
      drop_o <= start && full[wr_bank];
      if (!frame_i) begin
        wr_open <= 1'b0;
        wr_drop <= 1'b0;
      end else if (start) begin
        wr_open <= !full[wr_bank] && !last_i;
        wr_drop <= full[wr_bank] && !last_i;
        wr_addr <= wr_len;
      end else if (valid_i) begin
        if (wr_open) begin
          wr_addr <= wr_len;
          if (last_i) wr_open <= 1'b0;
        end
        if (wr_drop && last_i) wr_drop <= 1'b0;
      end
      if (commit) begin
        len_q[wr_bank] <= wr_len;
        wr_bank        <= !wr_bank;
      end
    end
  end

  logic [2*WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[mem_addr(wr_bank, wr_slot)] <= pack_vis(rdata_i, idata_i);
  end

  rd_state_t          rd_state;
  logic               rd_bank;
  logic [ABITS-1:0]   rd_addr;
  logic               vld_p1;
  logic               last_p1;
  logic [2*WIDTH-1:0] data_p1;

  logic               sk_ready;
  logic               pop;
  logic               release_bank;
  logic               issue;
  logic               other_full;
  logic [2:0]         occ;
  logic [1:0]         rd_sel;

  always_comb begin
    pop          = m_tvalid && m_tready;
    release_bank = pop && m_tlast;
    // Slots already claimed in the slice: head, skid entry and the RAM read in flight.
    occ          = 3'(m_tvalid) + 3'(!sk_ready) + 3'(vld_p1);
    issue        = (rd_state != RD_IDLE) && (rd_addr < len_q[rd_bank]) &&
                   (occ < 3'd2 + 3'(pop));
    other_full   = full[!rd_bank] || (commit && (wr_bank != rd_bank));
    rd_sel       = {rd_bank, !rd_bank};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) full <= 2'b00;
    else        full <= (full | (commit ? wr_sel : 2'b00)) & ~(release_bank ? rd_sel : 2'b00);
  end

  // Stage p1: registered RAM read, valid and last travel with the word.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      rd_addr  <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        last_p1 <= (rd_addr == len_q[rd_bank] - ONE);
        rd_addr <= rd_addr + ONE;
      end
      case (rd_state)
        RD_IDLE:   if (full[rd_bank]) rd_state <= RD_FETCH;
        RD_FETCH:  if (issue) rd_state <= RD_STREAM;
        RD_STREAM: begin
          if (release_bank) begin
            rd_bank  <= !rd_bank;
            rd_addr  <= '0;
            rd_state <= other_full ? RD_FETCH : RD_IDLE;
          end
        end
        default:   rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (issue) data_p1 <= mem[mem_addr(rd_bank, rd_addr)];
  end

  // Stage p2: output slice toward the readout.
  vis_skid_buffer #(
    .DW (2*WIDTH)
  ) u_skid (
    .clock   (clock),
    .reset_n (rst_n),
    .s_valid (vld_p1),
    .s_data  (data_p1),
    .s_last  (last_p1),
    .s_ready (sk_ready),
    .m_valid (m_tvalid),
    .m_ready (m_tready),
    .m_data  (m_tdata),
    .m_last  (m_tlast)
  );

endmodule

// File: tb/tb_vis_stream_buffer.sv
// Bench for vis_stream_buffer: directed scenarios plus randomized bursts against
// a queue-based model of committed bursts and bank occupancy.
module tb_vis_stream_buffer;

  localparam int W = 7;
  localparam int P = 3;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                frame_i = 1'b0;
  logic                valid_i = 1'b0;
  logic                first_i = 1'b0;
  logic                last_i = 1'b0;
  logic signed [W-1:0] rdata_i = '0;
  logic signed [W-1:0] idata_i = '0;
  logic                m_tready = 1'b0;
  logic                m_tvalid;
  logic                m_tlast;
  logic [2*W-1:0]      m_tdata;
  logic                drop_o;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  vis_stream_buffer #(.WIDTH(W), .PSUMS(P)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .frame_i  (frame_i),
    .valid_i  (valid_i),
    .first_i  (first_i),
    .last_i   (last_i),
    .rdata_i  (rdata_i),
    .idata_i  (idata_i),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tdata  (m_tdata),
    .drop_o   (drop_o)
  );

  // Reference model: expected beats in commit order, bursts held in banks.
  logic [2*W-1:0] exp_data [$];
  bit             exp_last [$];
  logic [2*W-1:0] cur [$];
  int             pending = 0;
  bit             m_open = 0;
  bit             m_dropping = 0;

  logic [2*W-1:0] got_data [$];
  bit             got_last [$];
  int             got_edge [$];
  int             drops = 0;
  int             cyc = 0;
  int             last_edge = 0;
  int             tv_rise = -1;
  int             rdy_mode = 1;
  int             pat_idx = 0;
  bit             hold_pend = 0;
  logic [2*W-1:0] hold_data;
  logic           hold_last;

  task automatic model_commit();
    for (int k = 0; k < cur.size(); k++) begin
      exp_data.push_back(cur[k]);
      exp_last.push_back(k == cur.size() - 1);
    end
    pending++;
    m_open = 0;
    last_edge = cyc + 1;
  endtask

  // Called just after a falling edge with inputs set; advances one clock.
  task automatic tick();
    int pb;
    bit acc;
    bit exp_drop;
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    case (rdy_mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      2:       m_tready = ($urandom_range(3) != 0);
      default: begin m_tready = pat[pat_idx % 6]; pat_idx++; end
    endcase
    if (hold_pend) begin
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== hold_data || m_tlast !== hold_last)
        $display("FAIL stall_hold: got tvalid=%b tdata=%h tlast=%b, want 1 %h %b",
                 m_tvalid, m_tdata, m_tlast, hold_data, hold_last);
      else passed++;
    end
    hold_pend = (m_tvalid === 1'b1) && !m_tready;
    hold_data = m_tdata;
    hold_last = m_tlast;
    pb = pending;
    exp_drop = frame_i && valid_i && first_i && (pb == 2);
    acc = (m_tvalid === 1'b1) && m_tready;
    if (acc) begin
      got_data.push_back(m_tdata);
      got_last.push_back(m_tlast);
      got_edge.push_back(cyc + 1);
      total++;
      if (exp_data.size() == 0) begin
        $display("FAIL unexpected_beat: got tdata=%h tlast=%b, want no beat", m_tdata, m_tlast);
      end else begin
        if (m_tdata !== exp_data[0] || m_tlast !== exp_last[0])
          $display("FAIL beat: got tdata=%h tlast=%b, want %h %b",
                   m_tdata, m_tlast, exp_data[0], exp_last[0]);
        else passed++;
        if (exp_last[0]) pending--;
        void'(exp_data.pop_front());
        void'(exp_last.pop_front());
      end
    end
    if (!frame_i) begin
      m_open = 0;
      m_dropping = 0;
    end else if (valid_i) begin
      if (first_i) begin
        if (pb == 2) begin
          m_open = 0;
          m_dropping = !last_i;
        end else begin
          cur.delete();
          cur.push_back({idata_i, rdata_i});
          m_open = 1;
          m_dropping = 0;
          if (last_i) model_commit();
        end
      end else if (m_open) begin
        if (cur.size() < P) cur.push_back({idata_i, rdata_i});
        if (last_i) model_commit();
      end else if (m_dropping && last_i) begin
        m_dropping = 0;
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    total++;
    if (drop_o !== exp_drop) $display("FAIL drop: got drop_o=%b, want %b", drop_o, exp_drop);
    else passed++;
    if (drop_o === 1'b1) drops++;
    if (m_tvalid === 1'b1 && tv_rise < 0) tv_rise = cyc;
  endtask

  task automatic idle_tick();
    frame_i = 1'b1; valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic signed [W-1:0] r, input logic signed [W-1:0] i,
                           input bit f, input bit l);
    frame_i = 1'b1; valid_i = 1'b1; first_i = f; last_i = l;
    rdata_i = r; idata_i = i;
    tick();
    valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic send_burst(input int n);
    for (int k = 0; k < n; k++)
      send_word(W'($urandom), W'($urandom), k == 0, k == n - 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_data.size() != 0 || m_tvalid === 1'b1) && n < budget) begin
      idle_tick();
      n++;
    end
    total++;
    if (exp_data.size() != 0)
      $display("FAIL drain_timeout: got %0d beats outstanding, want 0", exp_data.size());
    else passed++;
    repeat (4) idle_tick();
  endtask

  task automatic clear_log();
    got_data.delete(); got_last.delete(); got_edge.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    total += 4;
    if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b, want 0", m_tvalid); else passed++;
    if (m_tlast !== 1'b0) $display("FAIL reset_tlast: got %b, want 0", m_tlast); else passed++;
    if (m_tdata !== '0) $display("FAIL reset_tdata: got %h, want 0", m_tdata); else passed++;
    if (drop_o !== 1'b0) $display("FAIL reset_drop: got %b, want 0", drop_o); else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) idle_tick();
  endtask

  task automatic test_single();
    logic [2*W-1:0] w0 = {7'h7F, 7'h01};
    logic [2*W-1:0] w2 = {7'h7D, 7'h03};
    clear_log();
    rdy_mode = 1;
    tv_rise = -1;
    send_word(7'sd1, -7'sd1, 1, 0);
    send_word(7'sd2, -7'sd2, 0, 0);
    send_word(7'sd3, -7'sd3, 0, 1);
    drain(40);
    total += 3;
    if (tv_rise - last_edge != 3)
      $display("FAIL single_latency: got %0d edges, want 3", tv_rise - last_edge);
    else passed++;
    if (got_data.size() != 3) $display("FAIL single_count: got %0d beats, want 3", got_data.size());
    else passed++;
    if (got_data.size() == 3 && (got_data[0] !== w0 || got_data[2] !== w2 || got_last[2] !== 1'b1))
      $display("FAIL single_values: got %h %h, want %h %h", got_data[0], got_data[2], w0, w2);
    else if (got_data.size() == 3) passed++;
  endtask

  task automatic test_drop();
    clear_log();
    rdy_mode = 0;
    drops = 0;
    send_burst(3);
    send_burst(3);
    send_burst(3);
    repeat (4) idle_tick();
    rdy_mode = 1;
    drain(60);
    total += 2;
    if (drops != 1) $display("FAIL drop_pulses: got %0d, want 1", drops); else passed++;
    if (got_data.size() != 6) $display("FAIL drop_beats: got %0d, want 6", got_data.size());
    else passed++;
  endtask

  task automatic test_stall();
    clear_log();
    rdy_mode = 3;
    pat_idx = 0;
    send_burst(3);
    drain(60);
    total++;
    if (got_data.size() != 3) $display("FAIL stall_beats: got %0d, want 3", got_data.size());
    else passed++;
    rdy_mode = 1;
  endtask

  task automatic test_abort();
    clear_log();
    rdy_mode = 1;
    send_word(W'($urandom), W'($urandom), 1, 0);
    send_word(W'($urandom), W'($urandom), 0, 0);
    frame_i = 1'b0;
    tick();
    repeat (8) idle_tick();
    total++;
    if (got_data.size() != 0) $display("FAIL abort_output: got %0d beats, want 0", got_data.size());
    else passed++;
    send_burst(3);
    drain(40);
    total++;
    if (got_data.size() != 3) $display("FAIL abort_next: got %0d beats, want 3", got_data.size());
    else passed++;
  endtask

  task automatic test_short();
    clear_log();
    rdy_mode = 1;
    send_burst(2);
    repeat (6) idle_tick();
    send_burst(1);
    drain(40);
    total++;
    if (got_data.size() != 3 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1 || got_last[2] !== 1'b1)
      $display("FAIL short_last: got %0d beats, want 3 with tlast 0,1,1", got_data.size());
    else passed++;
  endtask

  task automatic test_overlong();
    clear_log();
    rdy_mode = 1;
    send_burst(5);
    drain(40);
    total++;
    if (got_data.size() != P) $display("FAIL overlong: got %0d beats, want %0d", got_data.size(), P);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int gap;
    clear_log();
    rdy_mode = 1;
    send_burst(3);
    send_burst(3);
    drain(60);
    total += 2;
    if (got_edge.size() != 6) begin
      $display("FAIL b2b_count: got %0d beats, want 6", got_edge.size());
    end else begin
      passed++;
      gap = got_edge[3] - got_edge[2];
      if (got_edge[1] - got_edge[0] != 1 || got_edge[2] - got_edge[1] != 1 || gap > 3)
        $display("FAIL b2b_timing: got burst gap %0d edges, want <=3 and no gap inside", gap);
      else passed++;
    end
  endtask

  task automatic test_random();
    int n;
    rdy_mode = 2;
    for (int b = 0; b < 40; b++) begin
      n = $urandom_range(5, 1);
      for (int k = 0; k < n; k++) begin
        if (k > 0 && $urandom_range(11) == 0) begin
          frame_i = 1'b0;
          tick();
          break;
        end
        send_word(W'($urandom), W'($urandom), (k == 0) || ($urandom_range(9) == 0), k == n - 1);
      end
      repeat ($urandom_range(3)) idle_tick();
    end
    drain(200);
    rdy_mode = 1;
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    clear_log();
    rdy_mode = 0;
    send_burst(3);
    while (m_tvalid !== 1'b1 && n < 10) begin idle_tick(); n++; end
    total++;
    if (m_tvalid !== 1'b1) $display("FAIL midreset_setup: got tvalid=%b, want 1", m_tvalid);
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    total += 4;
    if (m_tvalid !== 1'b0) $display("FAIL midreset_tvalid: got %b, want 0", m_tvalid); else passed++;
    if (m_tlast !== 1'b0) $display("FAIL midreset_tlast: got %b, want 0", m_tlast); else passed++;
    if (m_tdata !== '0) $display("FAIL midreset_tdata: got %h, want 0", m_tdata); else passed++;
    if (drop_o !== 1'b0) $display("FAIL midreset_drop: got %b, want 0", drop_o); else passed++;
    exp_data.delete(); exp_last.delete(); cur.delete();
    pending = 0; m_open = 0; m_dropping = 0; hold_pend = 0;
    @(negedge clock);
    reset_n = 1'b1;
    rdy_mode = 1;
    repeat (4) idle_tick();
    clear_log();
    send_burst(3);
    drain(40);
    total++;
    if (got_data.size() != 3) $display("FAIL midreset_after: got %0d beats, want 3", got_data.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_drop();
    test_stall();
    test_abort();
    test_short();
    test_overlong();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
